pls_adder_arbiter: RTL and testbench

- Shares one AXI-Stream floating-point adder (separate A/B operand channels, one result channel) between N_REQ requesters, e.g. several generator FSMs.
- Round-robin arbitration. Each issued operation is tagged with its requester ID in an in-order tag FIFO, and each adder result is routed back to the requester that issued it.
- Sits between the generator FSMs and the single adder IP instance in the generating subsystem.

---
 rtl/pls_arb_pkg.sv | 16 +
 rtl/pls_tag_fifo.sv | 57 +++++
 rtl/pls_adder_arbiter.sv | 156 +++++++++++++++
 tb/tb_pls_adder_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pls_arb_pkg.sv
// Shared types and constants for the pls_adder_arbiter slice.
package pls_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } issue_state_t;

    localparam int STAT_W = 16;

    // Requester ID width: clog2(n), never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pls_tag_fifo.sv
// In-order tag FIFO holding requester IDs of operations in flight in the adder.
// Head is presented first-word-fall-through on dout.
module pls_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pls_adder_arbiter.sv
// Round-robin sharing of one AXI-Stream FP adder among N_REQ requesters, with
// in-order result routing. Optional per-requester issue counters: PLS_ARB_STATS_EN.
//
//   state | meaning
//   IDLE  | waiting for a request and tag FIFO space; grants in this state
//   ISSUE | presenting captured operands on add_a / add_b until both accepted
module pls_adder_arbiter
    import pls_arb_pkg::*;
#(
    parameter int DATA_SIZE       = 32,
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_SIZE-1:0] req_a,
    input  logic [N_REQ*DATA_SIZE-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [DATA_SIZE-1:0]       rsp_data,
    output logic [DATA_SIZE-1:0]       add_a_tdata,
    output logic                       add_a_tvalid,
    input  logic                       add_a_tready,
    output logic [DATA_SIZE-1:0]       add_b_tdata,
    output logic                       add_b_tvalid,
    input  logic                       add_b_tready,
    input  logic [DATA_SIZE-1:0]       add_result_tdata,
    input  logic                       add_result_tvalid,
    output logic                       add_result_tready,
    output logic                       err_orphan,
    output logic [N_REQ*STAT_W-1:0]    stat_count
);

    localparam int IDW = id_width(N_REQ);

    issue_state_t   state_q, state_d;
    logic [IDW-1:0] rr_q, gnt_id, head;
    logic           grant, a_hs, b_hs;
    logic           a_done_q, b_done_q;
    logic           fifo_full, fifo_empty, pop;
    logic [DATA_SIZE-1:0] a_q, b_q;

    assign add_a_tvalid = (state_q == ISSUE) && !a_done_q;
    assign add_b_tvalid = (state_q == ISSUE) && !b_done_q;
    assign add_a_tdata  = a_q;
    assign add_b_tdata  = b_q;
    assign a_hs         = add_a_tvalid && add_a_tready;
    assign b_hs         = add_b_tvalid && add_b_tready;
    assign req_ready    = grant ? (N_REQ'(1) << gnt_id) : '0;

    always_comb begin
        int idx;
        logic [IDW-1:0] cand;
        idx     = 0;
        cand    = '0;
        grant   = 1'b0;
        gnt_id  = '0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // fifo_full comes from registered state, so a same-cycle pop never opens a slot.
                if (!fifo_full) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        idx  = (int'(rr_q) + k) % N_REQ;
                        cand = IDW'(idx);
                        if (!grant && req_valid[cand]) begin
                            grant  = 1'b1;
                            gnt_id = cand;
                        end
                    end
                end
                if (grant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if ((a_done_q || a_hs) && (b_done_q || b_hs)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q      <= req_a[gnt_id*DATA_SIZE +: DATA_SIZE];
                b_q      <= req_b[gnt_id*DATA_SIZE +: DATA_SIZE];
                rr_q     <= (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                a_done_q <= 1'b0;
                b_done_q <= 1'b0;
            end else begin
                if (a_hs) a_done_q <= 1'b1;
                if (b_hs) b_done_q <= 1'b1;
            end
            if (fifo_empty && add_result_tvalid) begin
                err_orphan <= 1'b1;
            end
        end
    end

    pls_tag_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (grant),
        .pop    (pop),
        .din    (gnt_id),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rsp_valid         = (!fifo_empty && add_result_tvalid) ? (N_REQ'(1) << head) : '0;
    assign rsp_data          = fifo_empty ? '0 : add_result_tdata;
    assign add_result_tready = !fifo_empty && rsp_ready[head];
    assign pop               = add_result_tvalid && add_result_tready;

`ifdef PLS_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [N_REQ];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (grant) begin
            stat_q[gnt_id] <= stat_q[gnt_id] + 1'b1;
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_count[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_pls_adder_arbiter.sv
// Scoreboard bench for pls_adder_arbiter with a 3-cycle-latency adder model.
module tb_pls_adder_arbiter;

    localparam int DW    = 32;
    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_data;
    logic [DW-1:0]   add_a_tdata, add_b_tdata;
    logic            add_a_tvalid, add_b_tvalid;
    logic            add_a_tready = 1'b0;
    logic            add_b_tready = 1'b0;
    logic [DW-1:0]   add_result_tdata = '0;
    logic            add_result_tvalid = 1'b0;
    logic            add_result_tready;
    logic            err_orphan;
    logic [N*16-1:0] stat_count;

    always #5 aclk = ~aclk;

    pls_adder_arbiter #(.DATA_SIZE(DW), .N_REQ(N), .MAX_OUTSTANDING(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .add_a_tdata(add_a_tdata), .add_a_tvalid(add_a_tvalid), .add_a_tready(add_a_tready),
        .add_b_tdata(add_b_tdata), .add_b_tvalid(add_b_tvalid), .add_b_tready(add_b_tready),
        .add_result_tdata(add_result_tdata), .add_result_tvalid(add_result_tvalid),
        .add_result_tready(add_result_tready),
        .err_orphan(err_orphan), .stat_count(stat_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference state
    int cyc = 0;
    int tb_rr, tb_cnt, grants;
    bit tb_busy, a_cap, b_cap, tb_err;
    logic [31:0] a_val, b_val;
    int          tag_q[$];
    logic [31:0] res_q[$], iss_a[$], iss_b[$], pipe_d[$];
    int          pipe_t[$];
    logic [31:0] pa [N][16];
    logic [31:0] pb [N][16];
    int ph [N];
    int pt [N];
    int stat_m [N];
    bit hold_res, orphan_drv;
    int b_stall, rsp_hold1, b_stall_seen, rsp_held_seen;

    // Positive normal operands only; truncating add is enough for the model.
    function automatic logic [31:0] fadd(input logic [31:0] x_in, input logic [31:0] y_in);
        logic [31:0] x, y;
        logic [7:0]  e;
        logic [24:0] mx, my, m;
        x = x_in; y = y_in;
        if (y[30:23] > x[30:23]) begin x = y_in; y = x_in; end
        e  = x[30:23];
        mx = {2'b01, x[22:0]};
        my = {2'b01, y[22:0]} >> (x[30:23] - y[30:23]);
        m  = mx + my;
        if (m[24]) begin m = m >> 1; e = e + 8'd1; end
        return {1'b0, e, m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b);
        pa[i][pt[i] % 16] = a;
        pb[i][pt[i] % 16] = b;
        pt[i]++;
    endtask

    function automatic bit busy_any();
        bit r;
        r = tb_busy || (tb_cnt > 0);
        for (int i = 0; i < N; i++) if (pt[i] != ph[i]) r = 1'b1;
        return r;
    endfunction

    task automatic step();
        int g, idx, head;
        logic [N-1:0] exp_rdy, exp_rv;
        bit exp_tr;
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = (pt[i] != ph[i]);
            req_a[i*DW +: DW]   = pa[i][ph[i] % 16];
            req_b[i*DW +: DW]   = pb[i][ph[i] % 16];
        end
        add_a_tready = 1'b1;
        add_b_tready = (b_stall == 0);
        if (b_stall > 0) b_stall--;
        rsp_ready = '1;
        if (rsp_hold1 > 0) begin rsp_ready[1] = 1'b0; rsp_hold1--; end
        add_result_tvalid = orphan_drv || (!hold_res && pipe_d.size() > 0 && pipe_t[0] <= cyc);
        add_result_tdata  = orphan_drv ? 32'hDEAD_BEEF : ((pipe_d.size() > 0) ? pipe_d[0] : 32'h0);
        #1;
        g = -1;
        exp_rdy = '0;
        if (!tb_busy && tb_cnt < DEPTH) begin
            for (int k = 0; k < N; k++) begin
                idx = (tb_rr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("a_tvalid", add_a_tvalid, tb_busy && !a_cap);
        check_eq("b_tvalid", add_b_tvalid, tb_busy && !b_cap);
        if (tb_busy && !a_cap) check_eq("a_tdata", add_a_tdata, iss_a[0]);
        if (tb_busy && !b_cap) check_eq("b_tdata", add_b_tdata, iss_b[0]);
        if (tb_busy && !b_cap && !add_b_tready) b_stall_seen++;
        head   = (tb_cnt > 0) ? tag_q[0] : 0;
        exp_rv = (tb_cnt > 0 && add_result_tvalid) ? (N'(1) << head) : '0;
        exp_tr = (tb_cnt > 0) && rsp_ready[head];
        check_eq("rsp_valid", rsp_valid, exp_rv);
        check_eq("result_tready", add_result_tready, exp_tr);
        check_eq("err_orphan", err_orphan, tb_err);
        if (exp_rv != 0 && exp_tr) check_eq("rsp_data", rsp_data, res_q[0]);
        if (exp_rv != 0 && !exp_tr) rsp_held_seen++;
        // advance the model to the state after this edge
        if (tb_cnt == 0 && add_result_tvalid) tb_err = 1'b1;
        if (add_result_tvalid && exp_tr) begin
            void'(pipe_d.pop_front()); void'(pipe_t.pop_front());
            void'(tag_q.pop_front());  void'(res_q.pop_front());
            tb_cnt--;
        end
        if (tb_busy && !a_cap && add_a_tready) begin a_cap = 1'b1; a_val = iss_a[0]; end
        if (tb_busy && !b_cap && add_b_tready) begin b_cap = 1'b1; b_val = iss_b[0]; end
        if (tb_busy && a_cap && b_cap) begin
            pipe_d.push_back(fadd(a_val, b_val));
            pipe_t.push_back(cyc + LAT);
            void'(iss_a.pop_front()); void'(iss_b.pop_front());
            tb_busy = 1'b0;
        end
        if (g >= 0) begin
            tag_q.push_back(g);
            res_q.push_back(fadd(pa[g][ph[g] % 16], pb[g][ph[g] % 16]));
            iss_a.push_back(pa[g][ph[g] % 16]);
            iss_b.push_back(pb[g][ph[g] % 16]);
            ph[g]++;
            tb_rr     = (g + 1) % N;
            tb_cnt++;
            stat_m[g] = (stat_m[g] + 1) & 16'hFFFF;
            tb_busy   = 1'b1;
            a_cap     = 1'b0;
            b_cap     = 1'b0;
            grants++;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy_any() && n < budget) begin step(); n++; end
        if (n >= budget) check_eq("drain_timeout", 0, 1);
        repeat (2) step();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        req_valid = '0; rsp_ready = '0; add_a_tready = 1'b0; add_b_tready = 1'b0;
        add_result_tvalid = 1'b0;
        tag_q.delete(); res_q.delete(); iss_a.delete(); iss_b.delete();
        pipe_d.delete(); pipe_t.delete();
        tb_rr = 0; tb_cnt = 0; tb_busy = 0; a_cap = 0; b_cap = 0; tb_err = 0;
        hold_res = 0; orphan_drv = 0; b_stall = 0; rsp_hold1 = 0;
        for (int i = 0; i < N; i++) begin ph[i] = 0; pt[i] = 0; stat_m[i] = 0; end
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_a_tvalid", add_a_tvalid, 0);
        check_eq("rst_b_tvalid", add_b_tvalid, 0);
        check_eq("rst_a_tdata", add_a_tdata, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_result_tready", add_result_tready, 0);
        check_eq("rst_err_orphan", err_orphan, 0);
        check_eq("rst_stat_count", stat_count, 0);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        int g0;
        do_reset();

        // single request on requester 2: 1.0 + 2.0
        push_op(2, 32'h3F80_0000, 32'h4000_0000);
        drain(100);

        // all four requesters, two ops each, from a fresh pointer
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_op(i, rand_fp(), rand_fp());
        drain(200);
        for (int i = 0; i < N; i++) begin
`ifdef PLS_ARB_STATS_EN
            check_eq("stat_after_8", stat_count[i*16 +: 16], 16'd2);
`else
            check_eq("stat_tied_0", stat_count[i*16 +: 16], 16'd0);
`endif
        end

        // B channel stalled for 5 cycles while A is ready
        b_stall = 6;
        b_stall_seen = 0;
        push_op(3, rand_fp(), rand_fp());
        push_op(0, rand_fp(), rand_fp());
        drain(100);
        check_eq("b_stall_cycles", b_stall_seen, 5);

        // results withheld: only DEPTH grants until the first pop
        hold_res = 1'b1;
        g0 = grants;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 3; i++) push_op(i, rand_fp(), rand_fp());
        repeat (40) step();
        check_eq("full_grants", grants - g0, 8);
        hold_res = 1'b0;
        drain(300);
        check_eq("full_total", grants - g0, 9);

        // requester 1 stalls its result at the FIFO head
        rsp_hold1 = 12;
        rsp_held_seen = 0;
        push_op(1, rand_fp(), rand_fp());
        drain(100);
        check_eq("rsp_held", rsp_held_seen >= 4, 1);

`ifdef PLS_ARB_STATS_EN
        for (int i = 0; i < N; i++) check_eq("stat_model", stat_count[i*16 +: 16], stat_m[i]);
`endif

        // orphan result with empty tag FIFO
        orphan_drv = 1'b1;
        step();
        orphan_drv = 1'b0;
        repeat (3) step();
        check_eq("orphan_sticky", err_orphan, 1);
        do_reset();
        step();
        check_eq("orphan_cleared", err_orphan, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
